// File: rtl/pdm_integrator.sv
// Integrate-and-decimate stage following the PDM comb: keeps a running sum of the
// signed comb stream, emits one registered sample per DECIMATION accepted inputs.
module pdm_integrator #(
    parameter int WINDOW_LEN = 250,
    parameter int DECIMATION = 250,
    parameter int DATA_WIDTH = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic [1:0]            data_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  err_o
);

    localparam int CNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATION - 1);
    localparam logic signed [DATA_WIDTH-1:0] ACC_MAX = DATA_WIDTH'(WINDOW_LEN);

    logic signed [DATA_WIDTH-1:0] r_acc;
    logic        [DATA_WIDTH-1:0] r_data;
    logic        [CNT_W-1:0]      r_cnt;
    logic                         r_valid;
    logic                         r_err;

    logic signed [DATA_WIDTH-1:0] w_data_ext;
    logic signed [DATA_WIDTH-1:0] w_acc_next;
    logic                         w_last;
    logic                         w_bad;

    assign w_data_ext = {{(DATA_WIDTH-2){data_i[1]}}, data_i};
    assign w_acc_next = r_acc + w_data_ext;
    assign w_last     = (r_cnt == CNT_LAST);

    // A well-formed comb never sends -2 and keeps the sum inside 0..WINDOW_LEN.
    assign w_bad = (data_i == 2'b10) || w_acc_next[DATA_WIDTH-1] || (w_acc_next > ACC_MAX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (!en_i) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (valid_i) begin
            r_acc <= w_acc_next;
            if (w_last) begin
                r_cnt   <= '0;
                r_data  <= w_acc_next;
                r_valid <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_valid <= 1'b0;
            end
            if (w_bad) begin
                r_err <= 1'b1;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    // The strobe is masked combinationally so it disappears as soon as enable drops.
    assign valid_o = r_valid & en_i;
    assign data_o  = r_data;
    assign err_o   = r_err;

endmodule
